gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//  Parametrised synchronous up/down counter with registered Gray-code and binary outputs.
//  Successor to the fixed 4-bit combinational binary-to-Gray converter: width-generic,
//  loadable, with wrap/saturate modes and a terminal-count flag.
//  Used as a pointer generator for clock-domain-crossing FIFOs and as a rotary-position source.
// PARAMETERS
//  WIDTH     4      counter width in bits (>=2)
//  SATURATE  0      0 = wrap at boundaries, 1 = hold at boundaries
//  INIT      0      binary reset value (0 .. 2**WIDTH-1)
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      step enable
//  up_dn     in   1      1 = count up, 0 = count down (sampled only when en=1)
//  load      in   1      synchronous load strobe
//  load_bin  in   WIDTH  binary value loaded when load=1
//  bin       out  WIDTH  registered binary count
//  gray      out  WIDTH  registered Gray code of bin
//  tc        out  1      registered terminal-count flag
// BEHAVIOUR
//  - Reset (async assert, sync release): bin=INIT, gray=INIT^(INIT>>1), tc=0.
//  - All outputs are registered. bin and gray always update on the same edge and
//    are coherent every cycle: gray == bin ^ (bin>>1).
//  - Priority per edge: load > en > hold.
//    load=1: bin<=load_bin, tc<=0, regardless of en/up_dn.
//    en=1, up_dn=1: bin<=bin+1; en=1, up_dn=0: bin<=bin-1 (modulo 2**WIDTH).
//    en=0, load=0: bin, gray hold; tc<=0.
//  - Boundaries (MAX = 2**WIDTH-1):
//    SATURATE=0: up from MAX -> 0 and down from 0 -> MAX. tc=1 for exactly the one
//      cycle in which the wrapped value is presented.
//    SATURATE=1: up at MAX or down at 0 -> bin holds. tc=1 for each cycle following
//      a step attempted at the boundary.
//  - Latency: one cycle from the enabling edge to a new bin/gray/tc.
//  - Every enabled non-saturated step changes exactly one gray bit; load may change any number.
//  - Reset asserted mid-count returns all outputs to reset values immediately,
//    with no dependency on clk.
//  - Direction reversal between consecutive steps is legal and takes effect on the next edge.
//  - The Gray output is computed from next-state binary and registered, never decoded
//    combinationally from the bin output, so gray is glitch-free for CDC use.
// STRUCTURE
//  - Package gray_pkg: function bin2gray(WIDTH-generic), function gray2bin (XOR prefix
//    scan), localparam MODE_WRAP=0 / MODE_SAT=1.
//  - Single module: next-state logic (load/step/boundary mux), a state register for
//    bin/gray/tc, and bin2gray from the package applied to the next state.
//  - No sub-module is needed; gray2bin lives in the package for the FIFO and the bench.
// TESTING (WIDTH=4 unless noted)
//  1. rst=1 with INIT=5, then release -> bin=0101, gray=0111, tc=0, with no clk edge needed.
//  2. en=1, up_dn=1 for 16 cycles from 0 -> gray sequence 0000,0001,0011,0010,...,1000;
//     tc=1 only when bin=0000 after 1111; every step has gray Hamming distance 1.
//  3. load=1, load_bin=0011, en=1 in the same cycle -> bin=0011, gray=0010 (load wins); then
//     up_dn=0 for 4 steps -> 0010,0001,0000,1111 with tc=1 on 1111 (SATURATE=0).
//  4. SATURATE=1, load 1110, up 3 steps -> bin 1111,1111,1111; tc=0,1,1; down 1 step -> 1110, tc=0.
//  5. rst pulsed asynchronously mid-count (between edges) -> outputs return to INIT at once;
//     counting resumes on the first edge after release.
//  6. WIDTH=8 random en/up_dn/load over 10k cycles against a reference model -> bin matches
//     the model, gray2bin(gray)==bin, and Hamming distance <=1 on non-load steps.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants. Used by the counter,
// by CDC FIFOs that decode synchronised pointers, and by the testbench.
package gray_pkg;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;
  // Widest counter the helpers cover; callers zero-extend and truncate.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix scan from the MSB down.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Loadable up/down counter with registered binary and Gray outputs and a
// terminal-count flag; wraps or saturates at the boundaries.
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int          SATURATE = MODE_WRAP,
  parameter int unsigned INIT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(INIT_BIN)));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;
  logic             w_boundary;

  // The step in the requested direction would cross MAX->0 or 0->MAX.
  assign w_boundary = up_dn ? (r_bin == '1) : (r_bin == '0);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (load) begin
      w_bin_nxt = load_bin;
    end else if (en) begin
      w_tc_nxt = w_boundary;
      if (!(SATURATE == MODE_SAT && w_boundary)) begin
        w_bin_nxt = up_dn ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
      end
    end
  end

  // Gray comes from the next-state binary so the registered code never glitches.
  assign w_gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));

  // NOTE: sequential state uses non-blocking assignments so all three
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= INIT_BIN;
      r_gray <= INIT_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign tc   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios on 4-bit wrap and
// saturate instances, then randomized 8-bit runs against a behavioural model.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int A_INIT = 5;
  localparam int C_INIT = 8'hA5;
  localparam int D_INIT = 8'hFE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // a: WIDTH=4 wrap INIT=5; b: WIDTH=4 saturate INIT=0
  logic       a_en, a_up, a_ld, a_tc;
  logic [3:0] a_lb, a_bin, a_gray;
  logic       b_en, b_up, b_ld, b_tc;
  logic [3:0] b_lb, b_bin, b_gray;
  // c: WIDTH=8 wrap, d: WIDTH=8 saturate, shared stimulus
  logic       c_en, c_up, c_ld, c_tc, d_tc;
  logic [7:0] c_lb, c_bin, c_gray, d_bin, d_gray;

  gray_counter #(.WIDTH(4), .SATURATE(MODE_WRAP), .INIT(A_INIT)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load(a_ld), .load_bin(a_lb),
    .bin(a_bin), .gray(a_gray), .tc(a_tc));

  gray_counter #(.WIDTH(4), .SATURATE(MODE_SAT), .INIT(0)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .load(b_ld), .load_bin(b_lb),
    .bin(b_bin), .gray(b_gray), .tc(b_tc));

  gray_counter #(.WIDTH(8), .SATURATE(MODE_WRAP), .INIT(C_INIT)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .load(c_ld), .load_bin(c_lb),
    .bin(c_bin), .gray(c_gray), .tc(c_tc));

  gray_counter #(.WIDTH(8), .SATURATE(MODE_SAT), .INIT(D_INIT)) dut_d (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .load(c_ld), .load_bin(c_lb),
    .bin(d_bin), .gray(d_gray), .tc(d_tc));

  function automatic logic [7:0] gray_of(input int v);
    return 8'(v ^ (v >> 1));
  endfunction

  // Reference step: plain integer arithmetic on the count value.
  task automatic model_step(input int maxv, input bit sat, input bit ld, input bit en,
                            input bit up, input int lb, inout int m, output bit t);
    t = 1'b0;
    if (ld) begin
      m = lb;
    end else if (en) begin
      if (up) begin
        if (m == maxv) begin t = 1'b1; m = sat ? maxv : 0; end
        else m = m + 1;
      end else begin
        if (m == 0) begin t = 1'b1; m = sat ? 0 : maxv; end
        else m = m - 1;
      end
    end
  endtask

  task automatic a_cycle(input bit ld, input bit en, input bit up, input logic [3:0] lb);
    @(negedge clk);
    a_ld = ld; a_en = en; a_up = up; a_lb = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input bit ld, input bit en, input bit up, input logic [3:0] lb);
    @(negedge clk);
    b_ld = ld; b_en = en; b_up = up; b_lb = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({a_bin, a_gray, a_tc} !== {4'b0101, 4'b0111, 1'b0}) begin
      n_err++;
      $display("FAIL reset_assert_a: got bin=%b gray=%b tc=%b, want 0101/0111/0",
               a_bin, a_gray, a_tc);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({a_bin, a_gray, a_tc} !== {4'b0101, 4'b0111, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release_a: got bin=%b gray=%b tc=%b, want 0101/0111/0",
               a_bin, a_gray, a_tc);
    end
    n_vec++;
    if ({b_bin, b_gray, b_tc} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_release_b: got bin=%b gray=%b tc=%b, want 0000/0000/0",
               b_bin, b_gray, b_tc);
    end
    n_vec++;
    if ({c_bin, c_gray, c_tc, d_bin, d_gray, d_tc} !==
        {8'(C_INIT), gray_of(C_INIT), 1'b0, 8'(D_INIT), gray_of(D_INIT), 1'b0}) begin
      n_err++;
      $display("FAIL reset_release_cd: got c=%h/%h/%b d=%h/%h/%b, want c=%h/%h/0 d=%h/%h/0",
               c_bin, c_gray, c_tc, d_bin, d_gray, d_tc,
               8'(C_INIT), gray_of(C_INIT), 8'(D_INIT), gray_of(D_INIT));
    end
  endtask

  task automatic test_count_up();
    logic [3:0] prev_g;
    a_cycle(1'b1, 1'b0, 1'b1, 4'd0);
    prev_g = a_gray;
    for (int i = 1; i <= 16; i++) begin
      int eb;
      eb = i % 16;
      a_cycle(1'b0, 1'b1, 1'b1, 4'd0);
      n_vec++;
      if ({a_bin, a_gray, a_tc} !== {4'(eb), 4'(gray_of(eb)), (eb == 0)}) begin
        n_err++;
        $display("FAIL count_up step %0d: got bin=%b gray=%b tc=%b, want %b/%b/%b",
                 i, a_bin, a_gray, a_tc, 4'(eb), 4'(gray_of(eb)), (eb == 0));
      end
      n_vec++;
      if ($countones(a_gray ^ prev_g) != 1) begin
        n_err++;
        $display("FAIL count_up_hamming step %0d: got distance %0d, want 1",
                 i, $countones(a_gray ^ prev_g));
      end
      prev_g = a_gray;
    end
  endtask

  task automatic test_load_priority_down();
    int exp_b [4] = '{2, 1, 0, 15};
    a_cycle(1'b1, 1'b1, 1'b1, 4'b0011);
    n_vec++;
    if ({a_bin, a_gray, a_tc} !== {4'b0011, 4'b0010, 1'b0}) begin
      n_err++;
      $display("FAIL load_priority: got bin=%b gray=%b tc=%b, want 0011/0010/0",
               a_bin, a_gray, a_tc);
    end
    for (int i = 0; i < 4; i++) begin
      a_cycle(1'b0, 1'b1, 1'b0, 4'd0);
      n_vec++;
      if ({a_bin, a_gray, a_tc} !== {4'(exp_b[i]), 4'(gray_of(exp_b[i])), (i == 3)}) begin
        n_err++;
        $display("FAIL count_down step %0d: got bin=%b gray=%b tc=%b, want %b/%b/%b",
                 i, a_bin, a_gray, a_tc, 4'(exp_b[i]), 4'(gray_of(exp_b[i])), (i == 3));
      end
    end
  endtask

  task automatic test_saturate();
    // {load, en, up, load_bin, expected bin, expected tc}
    int tbl [9][6] = '{
      '{1, 0, 0, 14, 14, 0}, '{0, 1, 1, 0, 15, 0}, '{0, 1, 1, 0, 15, 1},
      '{0, 1, 1, 0, 15, 1},  '{0, 1, 0, 0, 14, 0}, '{0, 0, 0, 0, 14, 0},
      '{1, 1, 0, 1, 1, 0},   '{0, 1, 0, 0, 0, 0},  '{0, 1, 0, 0, 0, 1}};
    for (int i = 0; i < 9; i++) begin
      b_cycle(tbl[i][0] != 0, tbl[i][1] != 0, tbl[i][2] != 0, 4'(tbl[i][3]));
      n_vec++;
      if ({b_bin, b_gray, b_tc} !== {4'(tbl[i][4]), 4'(gray_of(tbl[i][4])), tbl[i][5] != 0}) begin
        n_err++;
        $display("FAIL saturate row %0d: got bin=%b gray=%b tc=%b, want %b/%b/%b",
                 i, b_bin, b_gray, b_tc, 4'(tbl[i][4]), 4'(gray_of(tbl[i][4])), tbl[i][5] != 0);
      end
    end
  endtask

  task automatic test_async_reset();
    a_cycle(1'b1, 1'b0, 1'b0, 4'd9);
    a_cycle(1'b0, 1'b1, 1'b1, 4'd0);
    a_cycle(1'b0, 1'b1, 1'b1, 4'd0);
    n_vec++;
    if ({a_bin, a_gray, a_tc} !== {4'd11, 4'(gray_of(11)), 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset_count: got bin=%b gray=%b tc=%b, want 1011/1110/0",
               a_bin, a_gray, a_tc);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({a_bin, a_gray, a_tc, b_bin, b_gray, b_tc} !==
        {4'b0101, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got a=%b/%b/%b b=%b/%b/%b, want a=0101/0111/0 b=0000/0000/0",
               a_bin, a_gray, a_tc, b_bin, b_gray, b_tc);
    end
    #1 rst = 1'b0;
    a_cycle(1'b0, 1'b1, 1'b1, 4'd0);
    n_vec++;
    if ({a_bin, a_gray, a_tc} !== {4'd6, 4'(gray_of(6)), 1'b0}) begin
      n_err++;
      $display("FAIL resume_after_reset: got bin=%b gray=%b tc=%b, want 0110/0101/0",
               a_bin, a_gray, a_tc);
    end
  endtask

  task automatic test_random();
    int  mc, md;
    bit  tcc, tcd, ld, en, up;
    int  lb;
    logic [7:0] pc, pd;
    mc = C_INIT; md = D_INIT;
    pc = c_gray; pd = d_gray;
    for (int i = 0; i < 10000; i++) begin
      ld = ($urandom_range(15) == 0);
      en = ($urandom_range(3) != 0);
      up = $urandom_range(1) != 0;
      case ($urandom_range(3))
        0:       lb = 0;
        1:       lb = 255;
        default: lb = $urandom_range(255);
      endcase
      @(negedge clk);
      c_ld = ld; c_en = en; c_up = up; c_lb = 8'(lb);
      @(posedge clk);
      #1;
      model_step(255, 1'b0, ld, en, up, lb, mc, tcc);
      model_step(255, 1'b1, ld, en, up, lb, md, tcd);
      n_vec++;
      if ({c_bin, c_gray, c_tc} !== {8'(mc), gray_of(mc), tcc}) begin
        n_err++;
        $display("FAIL random_wrap cycle %0d: got bin=%h gray=%h tc=%b, want %h/%h/%b",
                 i, c_bin, c_gray, c_tc, 8'(mc), gray_of(mc), tcc);
      end
      n_vec++;
      if ({d_bin, d_gray, d_tc} !== {8'(md), gray_of(md), tcd}) begin
        n_err++;
        $display("FAIL random_sat cycle %0d: got bin=%h gray=%h tc=%b, want %h/%h/%b",
                 i, d_bin, d_gray, d_tc, 8'(md), gray_of(md), tcd);
      end
      n_vec++;
      if (8'(gray2bin(64'(c_gray))) !== c_bin || 8'(gray2bin(64'(d_gray))) !== d_bin) begin
        n_err++;
        $display("FAIL random_gray2bin cycle %0d: got c %h->%h d %h->%h, want decode equal to bin",
                 i, c_gray, 8'(gray2bin(64'(c_gray))), d_gray, 8'(gray2bin(64'(d_gray))));
      end
      if (!ld) begin
        n_vec++;
        if ($countones(c_gray ^ pc) > 1 || $countones(d_gray ^ pd) > 1) begin
          n_err++;
          $display("FAIL random_hamming cycle %0d: got distances %0d/%0d, want <=1",
                   i, $countones(c_gray ^ pc), $countones(d_gray ^ pd));
        end
      end
      pc = c_gray; pd = d_gray;
    end
  endtask

  initial begin
    rst = 1'b1;
    a_en = 0; a_up = 0; a_ld = 0; a_lb = '0;
    b_en = 0; b_up = 0; b_ld = 0; b_lb = '0;
    c_en = 0; c_up = 0; c_ld = 0; c_lb = '0;
    test_reset();
    test_count_up();
    test_load_priority_down();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
